// File: rtl/uart_rx.sv
// 8N1-style UART deframer driven by an oversampling tick; one-cycle pulses
// report a good byte (data_valid) or a zero stop bit (framing_err).
module uart_rx #(
  parameter int Data_bits  = 8,
  parameter int Oversample = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [Data_bits-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
);
  localparam int TW = $clog2(Oversample);
  localparam int BW = $clog2(Data_bits + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(Oversample / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(Oversample - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(Data_bits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state, state_nxt;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [Data_bits-1:0] shift, shift_nxt, dout_nxt;
  logic                 dv_nxt, fe_nxt;

  assign rx_s = sync[1];

  // Idle-high line: synchronizer resets to 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      data_out    <= dout_nxt;
      data_valid  <= dv_nxt;
      framing_err <= fe_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    dout_nxt  = data_out;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    if (rx_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          tick_nxt = tick_cnt + 1'b1;
          // Half a bit after the edge: still low means a real start bit.
          if (tick_cnt == HALF_M1) begin
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end
          end
        end
        DATA: begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == FULL_M1) begin
            shift_nxt = {rx_s, shift[Data_bits-1:1]};
            tick_nxt  = '0;
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = STOP;
          end
        end
        STOP: begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == FULL_M1) begin
            tick_nxt = '0;
            if (rx_s) begin
              dout_nxt  = shift;
              dv_nxt    = 1'b1;
              state_nxt = IDLE;
            end else begin
              fe_nxt    = 1'b1;
              state_nxt = BRK;
            end
          end
        end
        BRK: begin
          // Wait out a held-low line so it cannot re-trigger as a new frame.
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand sequences and random frames checked
// cycle by cycle against a sample-point model of the serial line.
module tb_uart_rx;
  localparam int DB = 8;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n, rx_tick, rx;
  logic [7:0] data_out;
  logic       data_valid, framing_err, busy;

  uart_rx #(.Data_bits(DB), .Oversample(OS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid),
    .framing_err(framing_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, prints = 0;
  bit jitter_en = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
    end
  endtask

  // Tick every 4 clk, optionally stretched by 1-3 clk.
  initial begin
    rx_tick = 1'b0;
    forever begin
      @(negedge clk); rx_tick = 1'b1;
      @(negedge clk); rx_tick = 1'b0;
      repeat (jitter_en ? 2 + $urandom_range(1, 3) : 2) @(negedge clk);
    end
  end

  // Reference: line value seen two clocks late; bits read at fixed tick offsets
  // OS/2 + k*OS from the detecting tick.
  int         tick_count = 0;
  int         m_mode = 0;      // 0 idle, 1 in frame, 2 line held low after error
  int         m_n = 0, m_k;
  logic       s0 = 1'b1, s1 = 1'b1, m_rxs;
  logic [7:0] m_byte = '0;
  logic [7:0] exp_data = '0;
  logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    m_rxs = s1; s1 = s0; s0 = rx;
    exp_valid = 1'b0; exp_ferr = 1'b0;
    if (rx_tick) tick_count++;
    if (!rst_n) begin
      s0 = 1'b1; s1 = 1'b1; m_mode = 0; exp_data = '0; exp_busy = 1'b0;
    end else if (rx_tick) begin
      case (m_mode)
        0: if (!m_rxs) begin m_mode = 1; m_n = 0; end
        1: begin
          m_n++;
          if (m_n == OS / 2) begin
            if (m_rxs) m_mode = 0;
          end else if (m_n > OS / 2 && (m_n - OS / 2) % OS == 0) begin
            m_k = (m_n - OS / 2) / OS;
            if (m_k <= DB) m_byte[m_k-1] = m_rxs;
            else if (m_rxs) begin exp_valid = 1'b1; exp_data = m_byte; m_mode = 0; end
            else begin exp_ferr = 1'b1; m_mode = 2; end
          end
        end
        default: if (m_rxs) m_mode = 0;
      endcase
      exp_busy = (m_mode != 0);
    end
  end

  int vcnt = 0, fcnt = 0, last_vtick = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outputs", 32'({data_valid, framing_err, busy, data_out}),
            32'({exp_valid, exp_ferr, exp_busy, exp_data}));
      check("valid_ferr_excl", 32'(data_valid & framing_err), 32'd0);
      if (data_valid) begin vcnt++; last_vtick = tick_count; end
      if (framing_err) fcnt++;
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (rx_tick !== 1'b1);
    end
    @(negedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0; wait_ticks(OS);
    for (int b = 0; b < DB; b++) begin rx = d[b]; wait_ticks(OS); end
    rx = stop; wait_ticks(OS);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         idle;
    bit         jit;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t       tbl[8];
  int         ent_vtick[8];
  int         v0, f0, hold, idle;
  logic [7:0] b, last_good;
  logic       good;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 0,  4, 1'b0, 1, 0, 8'h55};
    tbl[1] = '{8'hA3, 1'b1, 0,  0, 1'b0, 1, 0, 8'hA3};
    tbl[2] = '{8'h0F, 1'b1, 0,  4, 1'b0, 1, 0, 8'h0F};
    tbl[3] = '{8'h3C, 1'b1, 0,  2, 1'b0, 1, 0, 8'h3C};
    tbl[4] = '{8'h81, 1'b0, 40, 4, 1'b0, 0, 1, 8'h3C};
    tbl[5] = '{8'h7E, 1'b1, 0,  3, 1'b0, 1, 0, 8'h7E};
    tbl[6] = '{8'h00, 1'b1, 0,  2, 1'b1, 1, 0, 8'h00};
    tbl[7] = '{8'hFF, 1'b1, 0,  2, 1'b1, 1, 0, 8'hFF};

    rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk); #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_ferr", 32'(framing_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; chk_en = 1'b1;
    wait_ticks(2);

    for (int i = 0; i < 8; i++) begin
      jitter_en = tbl[i].jit; v0 = vcnt; f0 = fcnt;
      send_frame(tbl[i].data, tbl[i].stop);
      if (tbl[i].hold > 0) begin
        wait_ticks(tbl[i].hold);
        check($sformatf("vec%0d_busy_held", i), 32'(busy), 32'd1);
      end
      rx = 1'b1;
      if (tbl[i].idle > 0) wait_ticks(tbl[i].idle);
      ent_vtick[i] = last_vtick;
      check($sformatf("vec%0d_valid_cnt", i), 32'(vcnt - v0), 32'(tbl[i].exp_v));
      check($sformatf("vec%0d_ferr_cnt", i), 32'(fcnt - f0), 32'(tbl[i].exp_f));
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(tbl[i].exp_d));
      check($sformatf("vec%0d_busy_end", i), 32'(busy), 32'd0);
    end
    check("b2b_tick_spacing", 32'(ent_vtick[2] - ent_vtick[1]), 32'd160);

    // Start-bit glitch
    jitter_en = 1'b0; v0 = vcnt; f0 = fcnt;
    rx = 1'b0; wait_ticks(3);
    check("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1; wait_ticks(8);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(vcnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(fcnt - f0), 32'd0);

    // Reset during data bit 4 of 0xF0
    v0 = vcnt; f0 = fcnt;
    rx = 1'b0; wait_ticks(OS);
    for (int k = 0; k < 4; k++) begin rx = 1'b0; wait_ticks(OS); end
    rx = 1'b1; wait_ticks(8);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_ferr", 32'(framing_err), 32'd0);
    rst_n = 1'b1;
    wait_ticks(60);
    check("midrst_no_valid", 32'(vcnt - v0), 32'd0);
    check("midrst_no_ferr", 32'(fcnt - f0), 32'd0);
    send_frame(8'h12, 1'b1); wait_ticks(4);
    check("after_rst_valid", 32'(vcnt - v0), 32'd1);
    check("after_rst_data", 32'(data_out), 32'h12);

    // Random frames on a jittered tick
    jitter_en = 1'b1; last_good = 8'h12;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom); good = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(0, 20); idle = $urandom_range(1, 5);
      v0 = vcnt; f0 = fcnt;
      send_frame(b, good);
      if (!good && hold > 0) wait_ticks(hold);
      rx = 1'b1; wait_ticks(idle);
      if (good) last_good = b;
      check($sformatf("rnd%0d_valid_cnt", i), 32'(vcnt - v0), good ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_ferr_cnt", i), 32'(fcnt - f0), good ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_data", i), 32'(data_out), 32'(last_good));
      check($sformatf("rnd%0d_busy", i), 32'(busy), 32'd0);
    end

    wait_ticks(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
